// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//
// Contents:
//   state_t        FSM state encoding (ST_IDLE = 1'b0, ST_RUN = 1'b1)
//   DEFAULT_WIDTH  default operand/result width in bits
package serial_addsub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_addsub_pkg

// File: rtl/full_adder_1b.sv
// One-bit full adder, purely combinational. The serial adder instantiates one,
// and the parallel adder blocks reuse the same cell.
//
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder_1b

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Two WIDTH-bit operands are processed LSB-first,
// one bit per clock, through a single full adder and a carry flop.
//
// Handshake: start is sampled only while idle (busy=0). An accepted start
// latches a, b and sub on that edge. busy is high for exactly WIDTH cycles.
// done pulses for one cycle, WIDTH clocks after the accepting edge. The
// controller is idle again during the done cycle, so a start held high then is
// accepted, giving one result per WIDTH+1 clocks. start while busy is ignored.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request
//   sub    in   0 = a+b, 1 = a-b (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   busy   out  operation in progress
//   done   out  single-cycle completion pulse
//   sum    out  result, held from one completion to the next
//   cout   out  carry out (for subtraction, 1 = no borrow)
//   ovf    out  two's-complement signed overflow
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter must hold WIDTH-1 without wrapping; sized for WIDTH to be safe.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;

    full_adder_1b u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {fa_s, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b, seed carry with 1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_next;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // carry currently holds the carry into the MSB.
                        sum   <= res_next;
                        cout  <= fa_c;
                        ovf   <= fa_c ^ carry;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT, WIDTH=8 ----------------
    logic       start8 = 1'b0;
    logic       sub8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    serial_addsub #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    // ---------------- DUT, WIDTH=3 ----------------
    logic       start3 = 1'b0;
    logic       sub3 = 1'b0;
    logic [2:0] a3 = '0;
    logic [2:0] b3 = '0;
    logic       busy3, done3, cout3, ovf3;
    logic [2:0] sum3;

    serial_addsub #(.WIDTH(3)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .sub   (sub3),
        .a     (a3),
        .b     (b3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3),
        .ovf   (ovf3)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [9:0] exp_q[$];      // {ovf, cout, sum} for 8-bit operations
    logic [7:0] last_sum = '0; // sum the bench expects the DUT to be holding

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One 8-bit operation with latency, busy-length, stability and result checks.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic is_sub,
                        input logic [9:0] expv, input string tag);
        int lat;
        int busy_cnt;
        bit stable;
        bit got;
        logic [9:0] e;
        exp_q.push_back(expv);
        a8 = ia; b8 = ib; sub8 = is_sub; start8 = 1'b1;
        @(negedge clk);            // start accepted on the edge just passed
        start8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        sub8 = ~is_sub;
        lat = 0; busy_cnt = 0; stable = 1'b1; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done8 === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy8 === 1'b1) busy_cnt++;
            if (sum8 !== last_sum) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        e = exp_q.pop_front();
        check({tag, "_result"}, 32'({ovf8, cout8, sum8}), 32'(e));
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_sum_stable"}, 32'(stable), 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
        last_sum = e[7:0];
    endtask

    // One 3-bit operation; returns {ovf, cout, sum}, or all ones on timeout.
    task automatic run3(input logic [2:0] ia, input logic [2:0] ib, input logic is_sub,
                        output logic [4:0] r);
        bit got;
        a3 = ia; b3 = ib; sub3 = is_sub; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done3 === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        r = got ? {ovf3, cout3, sum3} : 5'h1f;
    endtask

    // Reference for the 3-bit sweep.
    function automatic logic [4:0] model3(input logic [2:0] ia, input logic [2:0] ib, input logic is_sub);
        logic [2:0] bb;
        logic [3:0] full;
        logic       v;
        bb   = is_sub ? ~ib : ib;
        full = {1'b0, ia} + {1'b0, bb} + {3'b0, is_sub};
        v    = (ia[2] == bb[2]) && (full[2] != ia[2]);
        return {v, full[3], full[2:0]};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [4:0] r3;
        int lat;
        bit stable;
        bit got;

        // Reset with random inputs applied.
        rst_n = 1'b0;
        start8 = 1'($urandom_range(0, 1));
        sub8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        start3 = 1'($urandom_range(0, 1));
        a3 = 3'($urandom_range(0, 7));
        b3 = 3'($urandom_range(0, 7));
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_w3_outs", 32'({busy3, done3, ovf3, cout3, sum3}), 32'd0);
        start8 = 1'b0; start3 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Additions and subtractions, expected = {ovf, cout, sum}.
        run8(8'd100, 8'd27, 1'b0, {1'b0, 1'b0, 8'h7F}, "add_100_27");
        run8(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}, "add_ff_01");
        run8(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}, "add_7f_01");
        run8(8'd5, 8'd9, 1'b1, {1'b0, 1'b0, 8'hFC}, "sub_5_9");
        run8(8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F}, "sub_80_01");
        run8(8'h33, 8'h33, 1'b1, {1'b0, 1'b1, 8'h00}, "sub_33_33");

        // start held high through RUN: first op 0x10+0x20, operands change
        // mid-run, and the second op (0x05+0x03) is accepted in the done cycle.
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03;
        got = 1'b0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8 === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check("b2b_first_done", 32'(got), 32'd1);
        check("b2b_first_latency", 32'(lat), 32'd8);
        check("b2b_first_result", 32'({ovf8, cout8, sum8}), 32'({2'b00, 8'h30}));
        check("b2b_busy_in_done_cycle", 32'(busy8), 32'd0);
        @(negedge clk);            // second op accepted on the edge just passed
        start8 = 1'b0;
        a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
        check("b2b_second_busy", 32'(busy8), 32'd1);
        check("b2b_done_dropped", 32'(done8), 32'd0);
        got = 1'b0; lat = 1; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done8 === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (sum8 !== 8'h30) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("b2b_second_done", 32'(got), 32'd1);
        check("b2b_done_spacing", 32'(lat), 32'd9);
        check("b2b_sum_held", 32'(stable), 32'd1);
        check("b2b_second_result", 32'({ovf8, cout8, sum8}), 32'({2'b00, 8'h08}));
        @(negedge clk);
        check("b2b_idle_after", 32'({busy8, done8}), 32'd0);
        last_sum = 8'h08;

        // Reset four clocks into an operation.
        a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy_now", 32'(busy8), 32'd0);
        check("midrst_outs_zero", 32'({done8, ovf8, cout8, sum8}), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) got = 1'b1;
            if (i == 2) rst_n = 1'b1;
        end
        check("midrst_no_done", 32'(got), 32'd0);
        last_sum = 8'h00;
        run8(8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46}, "post_rst_add");

        // Exhaustive 3-bit sweep.
        for (int s = 0; s < 2; s++) begin
            for (int ia = 0; ia < 8; ia++) begin
                for (int ib = 0; ib < 8; ib++) begin
                    run3(3'(ia), 3'(ib), 1'(s), r3);
                    check($sformatf("w3_%0s_%0d_%0d", (s != 0) ? "sub" : "add", ia, ib),
                          32'(r3), 32'(model3(3'(ia), 3'(ib), 1'(s))));
                end
            end
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_addsub
